// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator core.
//   op_e         operation select (encodings above OP_SQRT are invalid)
//   state_e      core sequencing states
//   iter_count   number of ITER cycles an op spends in the datapath
package calc_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_DIV  = 3'b011,
      OP_SQRT = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   // mul and div retire one result bit per cycle; sqrt retires one root
   // bit (two radicand bits) per cycle. Single-pass ops never iterate.
   function automatic int unsigned iter_count(input op_e op, input int unsigned width);
      case (op)
         OP_MUL, OP_DIV: return width;
         OP_SQRT:        return width / 2;
         default:        return 0;
      endcase
   endfunction

endpackage

// File: rtl/calc_divsqrt_unit.sv
// calc_divsqrt_unit: shared restoring shift/subtract datapath for unsigned
// divide and digit-by-digit square root, plus the iteration down-counter.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   load           capture operands, mode and counter start value
//   mode_sqrt      1 = square root of opa, 0 = opa / opb
//   cnt_init       counter start value (iterations - 1)
//   opa, opb       dividend/radicand, divisor
//   step_en        perform one iteration this cycle
//   last           counter at terminal count (final iteration in progress)
//   res_next       quotient / root after this cycle's iteration
//   rem_next       remainder after this cycle's iteration
// The counter also serves as the iteration timer for the top-level mul.
module calc_divsqrt_unit
   import calc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  mode_sqrt,
   input  logic [CNT_W-1:0]      cnt_init,
   input  logic [DATA_WIDTH-1:0] opa,
   input  logic [DATA_WIDTH-1:0] opb,
   input  logic                  step_en,
   output logic                  last,
   output logic [DATA_WIDTH-1:0] res_next,
   output logic [DATA_WIDTH-1:0] rem_next
);

   localparam int unsigned W = DATA_WIDTH;

   // Partial remainder fits in W bits for both modes: div keeps it below
   // the divisor, sqrt keeps it at most 2*root (< 2^(W/2+1)).
   logic [W-1:0]     rem_q, rem_d, rem_step;
   logic [W-1:0]     sh_q, sh_d, sh_step;
   logic [W-1:0]     res_q, res_d, res_step;
   logic [W-1:0]     dvs_q, dvs_d;
   logic             sqrt_q, sqrt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W:0]       shifted;
   logic [W+1:0]     trial;
   logic             ge;

   always_comb begin
      if (sqrt_q) begin
         // bring down two radicand bits, trial subtrahend is 4*root + 1
         shifted = {rem_q[W-2:0], sh_q[W-1 -: 2]};
         trial   = {res_q, 2'b01};
         sh_step = {sh_q[W-3:0], 2'b00};
      end else begin
         shifted = {rem_q, sh_q[W-1]};
         trial   = {2'b00, dvs_q};
         sh_step = {sh_q[W-2:0], 1'b0};
      end
      ge       = ({1'b0, shifted} >= trial);
      rem_step = ge ? W'({1'b0, shifted} - trial) : shifted[W-1:0];
      res_step = {res_q[W-2:0], ge};

      rem_d  = rem_q;
      sh_d   = sh_q;
      res_d  = res_q;
      dvs_d  = dvs_q;
      sqrt_d = sqrt_q;
      cnt_d  = cnt_q;
      if (load) begin
         rem_d  = '0;
         sh_d   = opa;
         res_d  = '0;
         dvs_d  = opb;
         sqrt_d = mode_sqrt;
         cnt_d  = cnt_init;
      end else if (step_en) begin
         rem_d = rem_step;
         sh_d  = sh_step;
         res_d = res_step;
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q  <= '0;
         sh_q   <= '0;
         res_q  <= '0;
         dvs_q  <= '0;
         sqrt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         rem_q  <= rem_d;
         sh_q   <= sh_d;
         res_q  <= res_d;
         dvs_q  <= dvs_d;
         sqrt_q <= sqrt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign last     = (cnt_q == '0);
   assign res_next = res_step;
   assign rem_next = rem_step;

endmodule

// File: rtl/calc_core_p.sv
// calc_core_p: multi-cycle unsigned calculator core (add, sub, mul, div, sqrt).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op, opa, opb request and operands, accepted while ready=1
//   ready               core can accept start this cycle
//   done                one-cycle pulse, result/flags valid
//   result, result_hi   low/high result words, held until next done
//   overflow, div_zero, invalid   exception flags (at most one set)
//
// state | meaning
// IDLE  | waiting for start
// ITER  | mul/div/sqrt iterating, one bit per cycle
// DONE  | done pulse; new start accepted here back-to-back
module calc_core_p
   import calc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] opa,
   input  logic [DATA_WIDTH-1:0] opb,
   output logic                  ready,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] result_hi,
   output logic                  overflow,
   output logic                  div_zero,
   output logic                  invalid
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   state_e       state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [2*W-1:0] acc_q, acc_d, acc_step;
   logic [W-1:0] mcand_q, mcand_d;
   logic         ready_q, ready_d;
   logic         done_q, done_d;
   logic [W-1:0] result_q, result_d;
   logic [W-1:0] result_hi_q, result_hi_d;
   logic         overflow_q, overflow_d;
   logic         div_zero_q, div_zero_d;
   logic         invalid_q, invalid_d;

   logic [W:0]       add_sum, sub_dif, mul_sum;
   logic             accept;
   logic             du_load, du_sqrt, du_last;
   logic [CNT_W-1:0] du_cnt;
   logic [W-1:0]     du_res, du_rem;

   calc_divsqrt_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_divsqrt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (du_load),
      .mode_sqrt (du_sqrt),
      .cnt_init  (du_cnt),
      .opa       (opa),
      .opb       (opb),
      .step_en   (state_q == ITER),
      .last      (du_last),
      .res_next  (du_res),
      .rem_next  (du_rem)
   );

   always_comb begin
      add_sum = {1'b0, opa} + {1'b0, opb};
      sub_dif = {1'b0, opa} - {1'b0, opb};
      // shift-add: multiplier sits in the low half and is consumed LSB first
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_step = {mul_sum, acc_q[W-1:1]};
      accept   = start && ready_q;

      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      done_d      = 1'b0;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      overflow_d  = overflow_q;
      div_zero_d  = div_zero_q;
      invalid_d   = invalid_q;
      du_load     = 1'b0;
      du_sqrt     = 1'b0;
      du_cnt      = '0;

      case (state_q)
         ITER: begin
            acc_d = acc_step;
            if (du_last) begin
               state_d    = DONE;
               done_d     = 1'b1;
               overflow_d = 1'b0;
               div_zero_d = 1'b0;
               invalid_d  = 1'b0;
               if (op_q == OP_MUL) begin
                  result_d    = acc_step[W-1:0];
                  result_hi_d = acc_step[2*W-1:W];
                  overflow_d  = |acc_step[2*W-1:W];
               end else begin
                  result_d    = du_res;
                  result_hi_d = du_rem;
               end
            end
         end
         default: begin
            state_d = IDLE;
            if (accept) begin
               op_d       = op;
               overflow_d = 1'b0;
               div_zero_d = 1'b0;
               invalid_d  = 1'b0;
               case (op)
                  OP_ADD: begin
                     state_d     = DONE;
                     done_d      = 1'b1;
                     result_d    = add_sum[W-1:0];
                     result_hi_d = '0;
                     overflow_d  = add_sum[W];
                  end
                  OP_SUB: begin
                     state_d     = DONE;
                     done_d      = 1'b1;
                     result_d    = sub_dif[W-1:0];
                     result_hi_d = '0;
                     overflow_d  = sub_dif[W];
                  end
                  OP_MUL: begin
                     state_d = ITER;
                     mcand_d = opa;
                     acc_d   = {{W{1'b0}}, opb};
                     du_load = 1'b1;
                     du_cnt  = CNT_W'(iter_count(OP_MUL, W) - 1);
                  end
                  OP_DIV: begin
                     if (opb == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        result_d    = '1;
                        result_hi_d = opa;
                        div_zero_d  = 1'b1;
                     end else begin
                        state_d = ITER;
                        du_load = 1'b1;
                        du_cnt  = CNT_W'(iter_count(OP_DIV, W) - 1);
                     end
                  end
                  OP_SQRT: begin
                     state_d = ITER;
                     du_load = 1'b1;
                     du_sqrt = 1'b1;
                     du_cnt  = CNT_W'(iter_count(OP_SQRT, W) - 1);
                  end
                  default: begin
                     state_d     = DONE;
                     done_d      = 1'b1;
                     result_d    = '0;
                     result_hi_d = '0;
                     invalid_d   = 1'b1;
                  end
               endcase
            end
         end
      endcase

      ready_d = (state_d != ITER);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         overflow_q  <= 1'b0;
         div_zero_q  <= 1'b0;
         invalid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         overflow_q  <= overflow_d;
         div_zero_q  <= div_zero_d;
         invalid_q   <= invalid_d;
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign overflow  = overflow_q;
   assign div_zero  = div_zero_q;
   assign invalid   = invalid_q;

endmodule

// File: tb/tb_calc_core_p.sv
// tb_calc_core_p: directed test of calc_core_p at DATA_WIDTH=8 with
// hand-computed expected values and cycle-exact done latency.
module tb_calc_core_p;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] opa = 8'd0;
   logic [7:0] opb = 8'd0;
   logic       ready, done, overflow, div_zero, invalid;
   logic [7:0] result, result_hi;

   int n_chk  = 0;
   int n_pass = 0;
   int lat, ndone, first, k;

   calc_core_p #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .opa       (opa),
      .opb       (opb),
      .ready     (ready),
      .done      (done),
      .result    (result),
      .result_hi (result_hi),
      .overflow  (overflow),
      .div_zero  (div_zero),
      .invalid   (invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Issue one op, scramble the inputs right after acceptance, and return
   // the cycle (relative to the accept cycle) where done is seen.
   task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int l);
      @(negedge clk);
      op = o; opa = a; opb = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = o ^ 3'b001; opa = ~a; opb = ~b;
      l = 1;
      while (!done && l < 40) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic chk_res(input string tag, input int l, input int exp_l,
                          input logic [7:0] e_res, input logic [7:0] e_hi,
                          input logic [2:0] e_flags);
      chk({tag, " latency"}, l, exp_l);
      chk({tag, " result"}, 32'(result), 32'(e_res));
      chk({tag, " result_hi"}, 32'(result_hi), 32'(e_hi));
      chk({tag, " flags{ovf,dz,inv}"}, 32'({overflow, div_zero, invalid}), 32'(e_flags));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset ready", 32'(ready), 1);
      chk("reset done", 32'(done), 0);
      chk("reset result", 32'({result_hi, result}), 0);
      chk("reset flags", 32'({overflow, div_zero, invalid}), 0);
      rst_n = 1'b1;

      do_op(3'b000, 8'd200, 8'd100, lat);
      chk_res("add 200+100", lat, 1, 8'd44, 8'd0, 3'b100);
      @(negedge clk);
      chk("add done one cycle", 32'(done), 0);
      chk("add ready after", 32'(ready), 1);
      chk("add result held", 32'(result), 44);

      do_op(3'b001, 8'd5, 8'd9, lat);
      chk_res("sub 5-9", lat, 1, 8'd252, 8'd0, 3'b100);

      do_op(3'b010, 8'd15, 8'd17, lat);
      chk_res("mul 15*17", lat, 9, 8'd255, 8'd0, 3'b000);

      do_op(3'b010, 8'd16, 8'd16, lat);
      chk_res("mul 16*16", lat, 9, 8'd0, 8'd1, 3'b100);

      do_op(3'b011, 8'd100, 8'd7, lat);
      chk_res("div 100/7", lat, 9, 8'd14, 8'd2, 3'b000);

      do_op(3'b011, 8'd42, 8'd0, lat);
      chk_res("div 42/0", lat, 1, 8'd255, 8'd42, 3'b010);

      do_op(3'b100, 8'd200, 8'd0, lat);
      chk_res("sqrt 200", lat, 5, 8'd14, 8'd4, 3'b000);

      do_op(3'b100, 8'd255, 8'd9, lat);
      chk_res("sqrt 255", lat, 5, 8'd15, 8'd30, 3'b000);

      do_op(3'b110, 8'd3, 8'd4, lat);
      chk_res("invalid 110", lat, 1, 8'd0, 8'd0, 3'b001);

      // start pulsed while a mul is iterating must be ignored
      @(negedge clk);
      op = 3'b010; opa = 8'd3; opb = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mid-mul ready", 32'(ready), 0);
      ndone = 0;
      first = 0;
      for (int i = 1; i <= 14; i++) begin
         if (i > 1) @(negedge clk);
         if (done) begin
            ndone++;
            if (first == 0) first = i;
            chk("mid-mul result", 32'(result), 15);
         end
         if (i == 3) begin
            start = 1'b1; op = 3'b000; opa = 8'd1; opb = 8'd1;
         end
         if (i == 4) start = 1'b0;
      end
      chk("mid-mul done count", ndone, 1);
      chk("mid-mul done cycle", first, 9);

      // back-to-back: start held through DONE cycles
      @(negedge clk);
      op = 3'b000; opa = 8'd10; opb = 8'd20; start = 1'b1;
      @(negedge clk);
      chk("b2b add done", 32'(done), 1);
      chk("b2b add result", 32'(result), 30);
      op = 3'b001; opa = 8'd50; opb = 8'd8;
      @(negedge clk);
      chk("b2b sub done", 32'(done), 1);
      chk("b2b sub result", 32'(result), 42);
      chk("b2b sub flags", 32'({overflow, div_zero, invalid}), 0);
      op = 3'b010; opa = 8'd3; opb = 8'd4;
      @(negedge clk);
      start = 1'b0;
      chk("b2b mul ready", 32'(ready), 0);
      chk("b2b mul no done", 32'(done), 0);
      k = 3;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("b2b mul latency", k, 11);
      chk("b2b mul result", 32'(result), 12);

      // reset during div iteration discards the op
      @(negedge clk);
      op = 3'b011; opa = 8'd100; opb = 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst ready", 32'(ready), 1);
      chk("rst done", 32'(done), 0);
      chk("rst result", 32'({result_hi, result}), 0);
      chk("rst flags", 32'({overflow, div_zero, invalid}), 0);
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("rst no done", ndone, 0);

      do_op(3'b000, 8'd1, 8'd1, lat);
      chk_res("add 1+1", lat, 1, 8'd2, 8'd0, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/calc_core_p.md
Name: calc_core_p

Overview:
Parametrised multi-cycle unsigned integer calculator core. It is the next-generation DUT behind the calculator pin interface, and adds op select, a secondary result and exception flags to the existing start/ready/done handshake. Add and sub are single-pass; mul, div and sqrt are iterative radix-2. The core sits under the top-level calculator and is driven by the UART/command front end or the testbench driver.

Parameters:
DATA_WIDTH, 32, operand/result width in bits; must be even and >= 4.

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous reset, active low
start  in  1  request; accepted only while ready=1
op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101-111 invalid
opa  in  DATA_WIDTH  operand A (dividend, sqrt radicand)
opb  in  DATA_WIDTH  operand B (ignored for sqrt)
ready  out  1  core can accept start this cycle
done  out  1  one-cycle pulse; result/flags valid
result  out  DATA_WIDTH  low product / quotient / root / sum / difference
result_hi  out  DATA_WIDTH  high product / remainder / sqrt remainder / 0
overflow  out  1  add carry-out, sub borrow (opa<opb), mul high half non-zero
div_zero  out  1  div with opb==0
invalid  out  1  op in 101..111

Behaviour:
- Reset (rst_n=0 at a clk edge) forces state IDLE, ready=1, done=0, all data outputs and flags 0. This applies in every state; any in-flight operation is discarded with no done pulse.
- States are IDLE, ITER and DONE.
- ready=1 in IDLE and DONE, 0 in ITER. start while ready=0 is ignored, not queued.
- Start accepted in cycle N: op, opa and opb are latched at the end of N. Later input changes have no effect.
- add/sub/invalid/div-by-zero go directly to DONE, so done=1 in cycle N+1.
- mul, div (opb!=0): ITER for DATA_WIDTH cycles (N+1..N+W), then DONE in N+W+1.
- sqrt: ITER for W/2 cycles, then DONE in N+W/2+1.
- DONE lasts exactly one cycle, then goes to IDLE, or straight back to ITER/DONE if start=1 in the DONE cycle (back-to-back allowed).
- done is high only in DONE. result, result_hi and flags are updated on entry to DONE and held until the next DONE or reset.
- Arithmetic, all unsigned:
  - add: result = (opa+opb) mod 2^W; overflow = carry.
  - sub: result = (opa-opb) mod 2^W; overflow = borrow.
  - mul: shift-add over a 2W product; {result_hi,result} = opa*opb; overflow = (result_hi!=0).
  - div: restoring divider; result = floor(opa/opb); result_hi = opa mod opb.
  - div_zero: result = all ones, result_hi = opa, div_zero = 1, other flags 0.
  - sqrt: digit-by-digit; result = floor(sqrt(opa)) zero-extended; result_hi = opa - result^2.
  - invalid: result = 0, result_hi = 0, invalid = 1.
- At most one flag is set per operation. Flags are cleared on every new DONE.

Decomposition:
- Package calc_pkg holds:
  - op_e enum (OP_ADD..OP_SQRT, with any value >= 101 treated as invalid);
  - state_e {IDLE, ITER, DONE};
  - localparam function for the iteration count per op.
- One sub-module, calc_divsqrt_unit: a shared restoring shift/subtract datapath used by div and sqrt, with an iteration counter. The shift-add mul stays in the top level.

Test Plan (DATA_WIDTH=8):
- add 200+100 at start cycle N -> done in N+1, result=44, overflow=1. Then sub 5-9 -> result=252, overflow=1.
- mul 15*17 -> done in N+9, result=255, result_hi=0, overflow=0. mul 16*16 -> result=0, result_hi=1, overflow=1.
- div 100/7 -> done in N+9, result=14, result_hi=2. div 42/0 -> done in N+1, result=255, result_hi=42, div_zero=1.
- sqrt 200 -> done in N+5, result=14, result_hi=4. op=110 -> done in N+1, invalid=1, result=0.
- start pulsed mid-mul (ready=0) -> ignored, single done. start asserted in a DONE cycle -> next op accepted with no IDLE gap.
- rst_n=0 for one cycle during div ITER -> no done pulse; ready=1 and outputs 0 the next cycle. A following add 1+1 -> result=2.
